// File: rtl/db_req_arbiter.sv
// Shares one key-value DB lookup port between two fire-and-forget requesters.
// Per-port request FIFOs feed a round-robin output register; a tag queue routes in-order replies back.
module db_req_arbiter #(
    parameter int KEY_SIZE        = 96,
    parameter int FLAG_SIZE       = 4,
    parameter int REQ_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                 clk156,
    input  logic                 eth_rst_n,
    input  logic [KEY_SIZE-1:0]  req0_key,
    input  logic [FLAG_SIZE-1:0] req0_flag,
    input  logic                 req0_valid,
    input  logic [KEY_SIZE-1:0]  req1_key,
    input  logic [FLAG_SIZE-1:0] req1_flag,
    input  logic                 req1_valid,
    output logic                 rsp0_valid,
    output logic [FLAG_SIZE-1:0] rsp0_flag,
    output logic                 rsp1_valid,
    output logic [FLAG_SIZE-1:0] rsp1_flag,
    output logic [KEY_SIZE-1:0]  db_key,
    output logic [FLAG_SIZE-1:0] db_flag,
    output logic                 db_valid,
    input  logic                 db_ready,
    input  logic                 db_rsp_valid,
    input  logic [FLAG_SIZE-1:0] db_rsp_flag,
    output logic [7:0]           drop0_cnt,
    output logic [7:0]           drop1_cnt,
    output logic                 err_unexp
);
    localparam int ENTRY_W = KEY_SIZE + FLAG_SIZE;
    localparam int PTR_W   = $clog2(REQ_DEPTH);
    localparam int TAG_W   = $clog2(MAX_OUTSTANDING);
    localparam int OUT_W   = TAG_W + 1;
    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W+1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    logic [ENTRY_W-1:0]   fifo_mem [2][REQ_DEPTH];
    logic [PTR_W:0]       wr_ptr [2];
    logic [PTR_W:0]       rd_ptr [2];
    logic [ENTRY_W-1:0]   req_entry [2];
    logic [7:0]           drop_cnt [2];
    logic [FLAG_SIZE-1:0] rsp_flag [2];
    logic [1:0]           req_valid, fifo_empty, fifo_full, pop, push_ok, drop, rsp_valid;
    logic                 grant, last_grant, load_en, rsp_accept;
    logic [ENTRY_W-1:0]   head_entry;
    logic                 tag_mem [MAX_OUTSTANDING];
    logic [TAG_W-1:0]     tag_wr, tag_rd;
    logic [OUT_W-1:0]     outstanding;

    assign req_valid    = {req1_valid, req0_valid};
    assign req_entry[0] = {req0_key, req0_flag};
    assign req_entry[1] = {req1_key, req1_flag};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
            fifo_full[i]  = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                            (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
        end
    end

    // Under contention the port that did not win the previous load goes next.
    always_comb begin
        if (fifo_empty[0])      grant = 1'b1;
        else if (fifo_empty[1]) grant = 1'b0;
        else                    grant = ~last_grant;
    end

    // DB handshake: a request transfers on a clk156 edge where db_valid && db_ready;
    // while db_valid=1 and db_ready=0 the register holds db_key/db_flag stable.
    assign load_en    = (!db_valid || db_ready) && !(&fifo_empty) && (outstanding < OUT_MAX);
    assign pop        = load_en ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign push_ok    = req_valid & (~fifo_full | pop);
    assign drop       = req_valid & fifo_full & ~pop;
    assign rsp_accept = db_rsp_valid && (outstanding != '0);
    assign head_entry = fifo_mem[grant][rd_ptr[grant][PTR_W-1:0]];

    // Storage arrays carry no reset; the pointers define what is valid.
    always_ff @(posedge clk156) begin
        for (int i = 0; i < 2; i++) begin
            if (push_ok[i]) fifo_mem[i][wr_ptr[i][PTR_W-1:0]] <= req_entry[i];
        end
        if (load_en) tag_mem[tag_wr] <= grant;
    end

    always_ff @(posedge clk156) begin
        if (!eth_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
                drop_cnt[i] <= '0;
                rsp_flag[i] <= '0;
            end
            rsp_valid   <= '0;
            last_grant  <= 1'b1;
            tag_wr      <= '0;
            tag_rd      <= '0;
            outstanding <= '0;
            db_valid    <= 1'b0;
            db_key      <= '0;
            db_flag     <= '0;
            err_unexp   <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                if (pop[i])     rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
                if (drop[i] && drop_cnt[i] != 8'hFF) drop_cnt[i] <= drop_cnt[i] + 8'd1;
            end

            if (load_en) begin
                {db_key, db_flag} <= head_entry;
                db_valid   <= 1'b1;
                last_grant <= grant;
                tag_wr     <= tag_wr + TAG_ONE;
            end else if (db_ready) begin
                db_valid <= 1'b0;
            end

            if (load_en && !rsp_accept)      outstanding <= outstanding + OUT_ONE;
            else if (!load_en && rsp_accept) outstanding <= outstanding - OUT_ONE;

            rsp_valid <= '0;
            if (rsp_accept) begin
                rsp_valid[tag_mem[tag_rd]] <= 1'b1;
                rsp_flag[tag_mem[tag_rd]]  <= db_rsp_flag;
                tag_rd <= tag_rd + TAG_ONE;
            end
            if (db_rsp_valid && outstanding == '0) err_unexp <= 1'b1;
        end
    end

    assign rsp0_valid = rsp_valid[0];
    assign rsp1_valid = rsp_valid[1];
    assign rsp0_flag  = rsp_flag[0];
    assign rsp1_flag  = rsp_flag[1];
    assign drop0_cnt  = drop_cnt[0];
    assign drop1_cnt  = drop_cnt[1];

endmodule
